// File: rtl/redmule_pkg.sv
// Shared types and constants for the RedMulE job-offload front end.
package redmule_pkg;

  // Default job shape: X, W, Z addresses, MCFIG0, MCFIG1, MACFG.
  localparam int unsigned CTX_N_REGS = 6;
  localparam int unsigned CTX_ID_W   = 8;

  // Control registers sit directly past the staging block.
  localparam int unsigned CTX_COMMIT_REL = 0;
  localparam int unsigned CTX_STATUS_REL = 1;

  // STATUS word bit positions.
  localparam int unsigned CTX_STATUS_OCC_LSB     = 0;
  localparam int unsigned CTX_STATUS_OCC_W       = 8;
  localparam int unsigned CTX_STATUS_FULL_BIT    = 8;
  localparam int unsigned CTX_STATUS_RUNNING_BIT = 9;
  localparam int unsigned CTX_STATUS_OVERFL_BIT  = 10;
  localparam int unsigned CTX_STATUS_NEXTID_LSB  = 16;

  // One queued job: staging snapshot plus the ID it was committed under.
  typedef struct packed {
    logic [CTX_N_REGS-1:0][31:0] regs;
    logic [CTX_ID_W-1:0]         id;
  } ctx_job_t;

  // STATUS register layout, MSB first.
  typedef struct packed {
    logic [15:0] next_id;
    logic [4:0]  reserved;
    logic        overflow;
    logic        running;
    logic        full;
    logic [7:0]  occupancy;
  } ctx_queue_status_t;

endpackage

// File: rtl/redmule_ctx_fifo.sv
// Generic job storage: DEPTH entries, wrapping pointers, occupancy count.
// A push on a full queue is accepted when a pop frees a slot the same cycle.
module redmule_ctx_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [OCC_W-1:0]  occupancy_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [OCC_W-1:0]  occ_r;
  logic              pop_acc_s;
  logic              push_acc_s;

  // Pointers wrap at DEPTH-1 so non power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : ptr + PTR_W'(1);
  endfunction

  assign empty_o     = (occ_r == OCC_W'(0));
  assign full_o      = (occ_r == OCC_W'(DEPTH));
  assign occupancy_o = occ_r;
  assign data_o      = mem_r[rd_ptr_r];

  // Qualify push/pop against the current fill level.
  always_comb begin
    pop_acc_s  = pop_i & ~empty_o;
    push_acc_s = push_i & (~full_o | pop_acc_s);
  end

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (push_acc_s) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= ptr_next(wr_ptr_r);
      end
      if (pop_acc_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_acc_s, pop_acc_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: rtl/redmule_ctx_queue.sv
// RedMulE job-offload front end: staging registers written over a 32-bit
// register port are committed as ID-tagged jobs into a queue; the controller
// pops jobs and reports completion, which raises an event with the job ID.
module redmule_ctx_queue
  import redmule_pkg::*;
#(
  parameter int unsigned N_CONTEXT = 2,
  parameter int unsigned N_REGS    = CTX_N_REGS,
  parameter int unsigned ID_W      = CTX_ID_W,
  parameter int unsigned AW        = $clog2(N_REGS + 2)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [AW-1:0]        cfg_addr_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic [31:0]          cfg_rdata_o,
  output logic                 cfg_rvalid_o,
  output logic                 job_valid_o,
  input  logic                 job_ready_i,
  output logic [N_REGS*32-1:0] job_regs_o,
  output logic [ID_W-1:0]      job_id_o,
  input  logic                 done_i,
  output logic                 evt_o,
  output logic [ID_W-1:0]      evt_id_o,
  output logic                 busy_o
);

  localparam int unsigned OCC_W  = $clog2(N_CONTEXT + 1);
  localparam int unsigned JOB_W  = N_REGS * 32 + ID_W;
  localparam logic [AW-1:0] COMMIT_ADDR = AW'(N_REGS + CTX_COMMIT_REL);
  localparam logic [AW-1:0] STATUS_ADDR = AW'(N_REGS + CTX_STATUS_REL);

  logic [31:0]         staging_r [N_REGS];
  logic [ID_W-1:0]     next_id_r;
  logic                overflow_r;
  logic                running_r;
  logic [ID_W-1:0]     running_id_r;
  logic                evt_r;
  logic [ID_W-1:0]     evt_id_r;
  logic [31:0]         rdata_r;
  logic                rvalid_r;

  logic                wr_s;
  logic                rd_s;
  logic                commit_s;
  logic                pop_s;
  logic                push_s;
  logic                drop_s;
  logic                empty_s;
  logic                full_s;
  logic [OCC_W-1:0]    occ_s;
  logic [N_REGS*32-1:0] regs_flat_s;
  logic [JOB_W-1:0]    job_in_s;
  logic [JOB_W-1:0]    job_out_s;
  logic [31:0]         staging_rd_s;
  ctx_queue_status_t   status_s;
  logic [31:0]         rdata_s;

  // Port decode and queue handshake qualification.
  always_comb begin
    wr_s     = cfg_req_i & cfg_we_i;
    rd_s     = cfg_req_i & ~cfg_we_i;
    commit_s = wr_s & (cfg_addr_i == COMMIT_ADDR);
    pop_s    = ~empty_s & job_ready_i;
    push_s   = commit_s & (~full_s | pop_s);
    drop_s   = commit_s & full_s & ~pop_s;
  end

  // Pack staging into a job word laid out like ctx_job_t (regs above id).
  always_comb begin
    regs_flat_s = '0;
    for (int i = 0; i < int'(N_REGS); i++) regs_flat_s[i*32 +: 32] = staging_r[i];
    job_in_s = {regs_flat_s, next_id_r};
  end

  redmule_ctx_fifo #(
    .DEPTH  (N_CONTEXT),
    .DATA_W (JOB_W),
    .OCC_W  (OCC_W)
  ) i_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .data_i      (job_in_s),
    .data_o      (job_out_s),
    .empty_o     (empty_s),
    .full_o      (full_s),
    .occupancy_o (occ_s)
  );

  assign job_valid_o  = ~empty_s;
  assign job_regs_o   = job_out_s[JOB_W-1:ID_W];
  assign job_id_o     = job_out_s[ID_W-1:0];
  assign busy_o       = ~empty_s | running_r;
  assign evt_o        = evt_r;
  assign evt_id_o     = evt_id_r;
  assign cfg_rdata_o  = rdata_r;
  assign cfg_rvalid_o = rvalid_r;

  // Staging registers; retained across commits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(N_REGS); i++) staging_r[i] <= 32'h0;
    end else if (clear_i) begin
      for (int i = 0; i < int'(N_REGS); i++) staging_r[i] <= 32'h0;
    end else begin
      for (int i = 0; i < int'(N_REGS); i++) begin
        if (wr_s && (cfg_addr_i == AW'(i))) staging_r[i] <= cfg_wdata_i;
      end
    end
  end

  // ID counter advances only on accepted commits; a dropped commit is sticky-flagged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      next_id_r  <= '0;
      overflow_r <= 1'b0;
    end else if (clear_i) begin
      next_id_r  <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) next_id_r <= next_id_r + ID_W'(1);
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  // Running flag and completion event; a pop with done_i completes the old job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      running_r    <= 1'b0;
      running_id_r <= '0;
      evt_r        <= 1'b0;
      evt_id_r     <= '0;
    end else if (clear_i) begin
      running_r    <= 1'b0;
      running_id_r <= '0;
      evt_r        <= 1'b0;
      evt_id_r     <= '0;
    end else begin
      evt_r <= done_i & running_r;
      if (done_i && running_r) evt_id_r <= running_id_r;
      if (pop_s) begin
        running_r    <= 1'b1;
        running_id_r <= job_id_o;
      end else if (done_i) begin
        running_r <= 1'b0;
      end
    end
  end

  // Read mux: staging, COMMIT (next_id), STATUS, otherwise zero.
  always_comb begin
    staging_rd_s = 32'h0;
    for (int i = 0; i < int'(N_REGS); i++) begin
      staging_rd_s = staging_rd_s | ((cfg_addr_i == AW'(i)) ? staging_r[i] : 32'h0);
    end
    status_s           = '0;
    status_s.occupancy = 8'(occ_s);
    status_s.full      = full_s;
    status_s.running   = running_r;
    status_s.overflow  = overflow_r;
    status_s.next_id   = 16'(next_id_r);
    if (cfg_addr_i == COMMIT_ADDR) begin
      rdata_s = 32'(next_id_r);
    end else if (cfg_addr_i == STATUS_ADDR) begin
      rdata_s = status_s;
    end else if (cfg_addr_i < AW'(N_REGS)) begin
      rdata_s = staging_rd_s;
    end else begin
      rdata_s = 32'h0;
    end
  end

  // Registered read response; data holds until the next read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_r  <= 32'h0;
      rvalid_r <= 1'b0;
    end else if (clear_i) begin
      rdata_r  <= 32'h0;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= rd_s;
      if (rd_s) rdata_r <= rdata_s;
    end
  end

endmodule

// File: tb/tb_redmule_ctx_queue.sv
// Directed bench for redmule_ctx_queue with default parameters
// (N_CONTEXT=2, N_REGS=6, ID_W=8, AW=3: COMMIT at 6, STATUS at 7).
module tb_redmule_ctx_queue;

  localparam int unsigned N_REGS = 6;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned AW     = 3;
  localparam logic [AW-1:0] A_COMMIT = 3'd6;
  localparam logic [AW-1:0] A_STATUS = 3'd7;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 clear_i;
  logic                 cfg_req_i;
  logic                 cfg_we_i;
  logic [AW-1:0]        cfg_addr_i;
  logic [31:0]          cfg_wdata_i;
  logic [31:0]          cfg_rdata_o;
  logic                 cfg_rvalid_o;
  logic                 job_valid_o;
  logic                 job_ready_i;
  logic [N_REGS*32-1:0] job_regs_o;
  logic [ID_W-1:0]      job_id_o;
  logic                 done_i;
  logic                 evt_o;
  logic [ID_W-1:0]      evt_id_o;
  logic                 busy_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] d;

  redmule_ctx_queue dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .cfg_req_i    (cfg_req_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_rdata_o  (cfg_rdata_o),
    .cfg_rvalid_o (cfg_rvalid_o),
    .job_valid_o  (job_valid_o),
    .job_ready_i  (job_ready_i),
    .job_regs_o   (job_regs_o),
    .job_id_o     (job_id_o),
    .done_i       (done_i),
    .evt_o        (evt_o),
    .evt_id_o     (evt_id_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [AW-1:0] addr, input logic [31:0] data);
    cfg_req_i   = 1'b1;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = addr;
    cfg_wdata_i = data;
    tick();
    cfg_req_i   = 1'b0;
    cfg_we_i    = 1'b0;
  endtask

  task automatic cfg_read(input logic [AW-1:0] addr, output logic [31:0] data);
    cfg_req_i  = 1'b1;
    cfg_we_i   = 1'b0;
    cfg_addr_i = addr;
    tick();
    cfg_req_i  = 1'b0;
    chk("rd_rvalid", 32'(cfg_rvalid_o), 32'd1);
    data = cfg_rdata_o;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    cfg_req_i   = 1'b0;
    cfg_we_i    = 1'b0;
    cfg_addr_i  = 3'd0;
    cfg_wdata_i = 32'h0;
    job_ready_i = 1'b0;
    done_i      = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_valid",  32'(job_valid_o), 32'd0);
    chk("rst_busy",   32'(busy_o), 32'd0);
    chk("rst_evt",    32'(evt_o), 32'd0);
    chk("rst_rvalid", 32'(cfg_rvalid_o), 32'd0);
    chk("rst_rdata",  cfg_rdata_o, 32'h0);
    chk("rst_id",     32'(job_id_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // 1: STATUS after reset
    cfg_read(A_STATUS, d);
    chk("t1_status", d, 32'h0000_0000);
    chk("t1_valid",  32'(job_valid_o), 32'd0);
    chk("t1_busy",   32'(busy_o), 32'd0);
    tick();
    chk("t1_rvalid_drop", 32'(cfg_rvalid_o), 32'd0);

    // 2: single commit
    cfg_write(3'd0, 32'h1000_0000);
    cfg_write(A_COMMIT, 32'hDEAD_BEEF);
    chk("t2_valid", 32'(job_valid_o), 32'd1);
    chk("t2_id",    32'(job_id_o), 32'd0);
    chk("t2_reg0",  job_regs_o[31:0], 32'h1000_0000);
    cfg_read(A_STATUS, d);
    chk("t2_status", d, 32'h0001_0001);
    cfg_read(A_COMMIT, d);
    chk("t2_next_id", d, 32'h0000_0001);
    cfg_read(3'd0, d);
    chk("t2_staging0", d, 32'h1000_0000);

    // 3: fill and overflow
    cfg_write(A_COMMIT, 32'h0);
    cfg_write(A_COMMIT, 32'h0);
    cfg_read(A_STATUS, d);
    chk("t3_status", d, 32'h0002_0502);
    chk("t3_head_id", 32'(job_id_o), 32'd0);
    cfg_write(A_STATUS, 32'hFFFF_FFFF);
    cfg_read(A_STATUS, d);
    chk("t3_status_ro", d, 32'h0002_0502);

    // 4: full queue with same-cycle commit and pop
    do_clear();
    cfg_read(A_STATUS, d);
    chk("t4_clear_status", d, 32'h0);
    cfg_write(3'd0, 32'h0000_000A);
    cfg_write(A_COMMIT, 32'h0);
    cfg_write(3'd0, 32'h0000_000B);
    cfg_write(A_COMMIT, 32'h0);
    cfg_write(3'd0, 32'h0000_000C);
    cfg_read(A_STATUS, d);
    chk("t4_full_status", d, 32'h0002_0102);
    job_ready_i = 1'b1;
    cfg_write(A_COMMIT, 32'h0);
    job_ready_i = 1'b0;
    chk("t4_head_id1", 32'(job_id_o), 32'd1);
    chk("t4_head_reg1", job_regs_o[31:0], 32'h0000_000B);
    cfg_read(A_STATUS, d);
    chk("t4_status_push_pop", d, 32'h0003_0302);
    job_ready_i = 1'b1;
    done_i      = 1'b1;
    tick();
    job_ready_i = 1'b0;
    done_i      = 1'b0;
    chk("t4_evt_old",    32'(evt_o), 32'd1);
    chk("t4_evt_id_old", 32'(evt_id_o), 32'd0);
    chk("t4_head_id2",   32'(job_id_o), 32'd2);
    chk("t4_head_reg2",  job_regs_o[31:0], 32'h0000_000C);
    job_ready_i = 1'b1;
    tick();
    job_ready_i = 1'b0;
    chk("t4_empty",   32'(job_valid_o), 32'd0);
    chk("t4_busy",    32'(busy_o), 32'd1);
    chk("t4_evt_low", 32'(evt_o), 32'd0);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk("t4_evt_id2", 32'(evt_id_o), 32'd2);
    chk("t4_idle",    32'(busy_o), 32'd0);

    // 5: pop job 0 and complete it
    do_clear();
    cfg_write(3'd1, 32'h0000_0005);
    cfg_write(A_COMMIT, 32'h0);
    job_ready_i = 1'b1;
    tick();
    job_ready_i = 1'b0;
    chk("t5_valid", 32'(job_valid_o), 32'd0);
    chk("t5_busy",  32'(busy_o), 32'd1);
    cfg_read(A_STATUS, d);
    chk("t5_status_running", d, 32'h0001_0200);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk("t5_evt",    32'(evt_o), 32'd1);
    chk("t5_evt_id", 32'(evt_id_o), 32'd0);
    chk("t5_busy_fall", 32'(busy_o), 32'd0);
    tick();
    chk("t5_evt_one_cycle", 32'(evt_o), 32'd0);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk("t5_done_idle", 32'(evt_o), 32'd0);

    // 6: ID wrap over 257 commits while popping continuously
    do_clear();
    job_ready_i = 1'b1;
    for (int i = 0; i < 257; i++) begin
      cfg_write(A_COMMIT, 32'h0);
      chk($sformatf("t6_id_%0d", i), 32'(job_id_o), 32'(i % 256));
    end
    job_ready_i = 1'b0;
    chk("t6_busy_before", 32'(busy_o), 32'd1);
    // Clear outranks a simultaneous commit and done
    clear_i     = 1'b1;
    done_i      = 1'b1;
    cfg_req_i   = 1'b1;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = A_COMMIT;
    tick();
    clear_i   = 1'b0;
    done_i    = 1'b0;
    cfg_req_i = 1'b0;
    cfg_we_i  = 1'b0;
    chk("t6_clr_valid", 32'(job_valid_o), 32'd0);
    chk("t6_clr_busy",  32'(busy_o), 32'd0);
    chk("t6_clr_evt",   32'(evt_o), 32'd0);
    tick();
    chk("t6_clr_evt2",  32'(evt_o), 32'd0);
    cfg_read(A_STATUS, d);
    chk("t6_clr_status", d, 32'h0);

    // Asynchronous reset mid-operation
    cfg_write(A_COMMIT, 32'h0);
    job_ready_i = 1'b1;
    tick();
    job_ready_i = 1'b0;
    cfg_write(A_COMMIT, 32'h0);
    chk("ar_busy_pre", 32'(busy_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    done_i = 1'b1;
    #1;
    chk("ar_valid", 32'(job_valid_o), 32'd0);
    chk("ar_busy",  32'(busy_o), 32'd0);
    tick();
    done_i = 1'b0;
    rst_ni = 1'b1;
    tick();
    chk("ar_evt", 32'(evt_o), 32'd0);
    cfg_read(A_COMMIT, d);
    chk("ar_next_id", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
